// File: rtl/cnn_sdiv_seq_22s_8u.sv
// Sequential signed/unsigned divider: 22-bit signed dividend by 8-bit unsigned divisor.
// Restoring shift-subtract, one quotient bit per cycle, with saturation/wrap and divide-by-zero flag.
module cnn_sdiv_seq_22s_8u #(
  parameter logic [31:0] ID     = 32'd1,
  parameter int          SAT_EN = 1
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [21:0] din0,
  input  logic [7:0]  din1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [13:0] quot,
  output logic [8:0]  rem,
  output logic        sat,
  output logic        dz
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [13:0] LP_QMAX = 14'h1FFF;
  localparam logic [13:0] LP_QMIN = 14'h2000;

  state_t      r_state;
  logic [21:0] r_dvd;
  logic [21:0] r_quo;
  logic [7:0]  r_pr;
  logic [7:0]  r_div;
  logic        r_neg;
  logic [4:0]  r_cnt;
  logic [13:0] r_quot;
  logic [8:0]  r_rem;
  logic        r_sat;
  logic        r_dz;

  logic [21:0] w_din0_abs;
  logic [8:0]  w_shift;
  logic [9:0]  w_diff;
  logic        w_qbit;
  logic [7:0]  w_pr_next;
  logic [21:0] w_quo_next;
  logic [13:0] w_q_low;
  logic        w_q_ovf;
  logic [13:0] w_quot_fin;
  logic [8:0]  w_rem_fin;

  // Two's complement magnitude; -2^21 maps to 2^21, which still fits 22 unsigned bits.
  assign w_din0_abs = din0[21] ? (~din0 + 22'd1) : din0;

  assign w_shift    = {r_pr, r_dvd[21]};
  assign w_diff     = {1'b0, w_shift} - {2'b00, r_div};
  assign w_qbit     = ~w_diff[9];
  assign w_pr_next  = w_qbit ? w_diff[7:0] : w_shift[7:0];
  assign w_quo_next = {r_quo[20:0], w_qbit};

  // Low 14 bits of the signed quotient equal the negated low 14 bits of the magnitude.
  assign w_q_low    = r_neg ? (14'd0 - w_quo_next[13:0]) : w_quo_next[13:0];
  assign w_q_ovf    = r_neg ? (w_quo_next > 22'd8192) : (w_quo_next > 22'd8191);
  assign w_quot_fin = ((SAT_EN != 0) && w_q_ovf) ? (r_neg ? LP_QMIN : LP_QMAX) : w_q_low;
  assign w_rem_fin  = r_neg ? (9'd0 - {1'b0, w_pr_next}) : {1'b0, w_pr_next};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_quo   <= '0;
      r_pr    <= '0;
      r_div   <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_sat   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (din1 == 8'd0) begin
              r_quot  <= din0[21] ? LP_QMIN : LP_QMAX;
              r_rem   <= '0;
              r_sat   <= 1'b0;
              r_dz    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_dvd   <= w_din0_abs;
              r_div   <= din1;
              r_neg   <= din0[21];
              r_pr    <= '0;
              r_quo   <= '0;
              r_cnt   <= '0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_pr  <= w_pr_next;
          r_quo <= w_quo_next;
          r_dvd <= {r_dvd[20:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
          // The last iteration's bit is folded straight into the final result.
          if (r_cnt == 5'd21) begin
            r_quot  <= w_quot_fin;
            r_rem   <= w_rem_fin;
            r_sat   <= w_q_ovf;
            r_dz    <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign quot      = r_quot;
  assign rem       = r_rem;
  assign sat       = r_sat;
  assign dz        = r_dz;

endmodule

// File: tb/tb_cnn_sdiv_seq_22s_8u.sv
// Bench for cnn_sdiv_seq_22s_8u: saturating and wrapping instances driven in parallel,
// checked against directed vectors and an integer-arithmetic reference model.
module tb_cnn_sdiv_seq_22s_8u;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic [21:0] din0;
  logic [7:0]  din1;
  logic        out_ready;

  logic        in_ready_s, out_valid_s, sat_s, dz_s;
  logic [13:0] quot_s;
  logic [8:0]  rem_s;
  logic        in_ready_w, out_valid_w, sat_w, dz_w;
  logic [13:0] quot_w;
  logic [8:0]  rem_w;

  int total = 0;
  int bad   = 0;

  always #5 ap_clk = ~ap_clk;

  cnn_sdiv_seq_22s_8u #(.ID(32'd1), .SAT_EN(1)) dut_s (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .din0(din0), .din1(din1), .out_valid(out_valid_s), .out_ready(out_ready),
    .quot(quot_s), .rem(rem_s), .sat(sat_s), .dz(dz_s)
  );

  cnn_sdiv_seq_22s_8u #(.ID(32'd2), .SAT_EN(0)) dut_w (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .din0(din0), .din1(din1), .out_valid(out_valid_w), .out_ready(out_ready),
    .quot(quot_w), .rem(rem_w), .sat(sat_w), .dz(dz_w)
  );

  typedef struct packed {
    logic [13:0] q1;
    logic [8:0]  r;
    logic        s1;
    logic        dz;
    logic [13:0] q0;
    logic        s0;
  } exp_t;

  typedef struct {
    logic [21:0] a;
    logic [7:0]  b;
    exp_t        e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, then clip or wrap.
  function automatic exp_t model(input logic [21:0] a, input logic [7:0] b);
    exp_t e;
    int sa, q, r;
    bit ovf;
    sa = $signed(a);
    if (b == 8'd0) begin
      e.q1 = (sa < 0) ? 14'h2000 : 14'h1FFF;
      e.q0 = e.q1;
      e.r  = '0;
      e.s1 = 1'b0;
      e.s0 = 1'b0;
      e.dz = 1'b1;
    end else begin
      q   = sa / int'(b);
      r   = sa % int'(b);
      ovf = (q > 8191) || (q < -8192);
      e.q0 = q[13:0];
      e.q1 = ovf ? ((q > 0) ? 14'h1FFF : 14'h2000) : q[13:0];
      e.r  = r[8:0];
      e.s1 = ovf;
      e.s0 = ovf;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic run_op(input logic [21:0] a, input logic [7:0] b, input int hold, input exp_t e);
    int lat;
    lat = 0;
    while (!in_ready_s && lat < 60) begin
      @(posedge ap_clk); #1; lat++;
    end
    chk("ready_before_accept", {31'd0, in_ready_s}, 32'd1);
    din0 = a; din1 = b; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    din0 = 22'($urandom);
    din1 = 8'($urandom);
    lat = 1;
    while (!out_valid_s && lat < 40) begin
      @(posedge ap_clk); #1; lat++;
    end
    chk("latency", lat, (b == 8'd0) ? 32'd1 : 32'd23);
    chk("valid_w", {31'd0, out_valid_w}, 32'd1);
    for (int i = 0; i <= hold; i++) begin
      chk("quot_sat", {18'd0, quot_s}, {18'd0, e.q1});
      chk("rem", {23'd0, rem_s}, {23'd0, e.r});
      chk("sat_flag", {31'd0, sat_s}, {31'd0, e.s1});
      chk("dz", {31'd0, dz_s}, {31'd0, e.dz});
      chk("quot_wrap", {18'd0, quot_w}, {18'd0, e.q0});
      chk("rem_wrap", {23'd0, rem_w}, {23'd0, e.r});
      chk("sat_wrap", {31'd0, sat_w}, {31'd0, e.s0});
      chk("dz_wrap", {31'd0, dz_w}, {31'd0, e.dz});
      chk("ready_in_done", {31'd0, in_ready_s}, 32'd0);
      chk("valid_held", {31'd0, out_valid_s}, 32'd1);
      if (i < hold) begin
        @(posedge ap_clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", {31'd0, out_valid_s}, 32'd0);
    chk("ready_back", {31'd0, in_ready_s}, 32'd1);
    $display("op a=%0d b=%0d quot=%0d rem=%0d sat=%0b dz=%0b quot_w=%0d",
             $signed(a), b, $signed(quot_s), $signed(rem_s), sat_s, dz_s, $signed(quot_w));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, {31'd0, in_ready_s}, 32'd1);
    chk({nm, "_valid"}, {31'd0, out_valid_s}, 32'd0);
    chk({nm, "_outs"}, {8'd0, quot_s, rem_s, sat_s, dz_s}, 32'd0);
    chk({nm, "_outs_w"}, {8'd0, quot_w, rem_w, sat_w, dz_w}, 32'd0);
  endtask

  vec_t vt[14];
  int   acc[$];

  initial begin
    vt[0]  = '{22'd1000,               8'd7,   '{14'd142,  9'd6,    1'b0, 1'b0, 14'd142,  1'b0}};
    vt[1]  = '{-22'sd1000,             8'd7,   '{14'h3F72, 9'h1FA,  1'b0, 1'b0, 14'h3F72, 1'b0}};
    vt[2]  = '{22'd2097151,            8'd1,   '{14'h1FFF, 9'd0,    1'b1, 1'b0, 14'h3FFF, 1'b1}};
    vt[3]  = '{22'h200000,             8'd255, '{14'h2000, 9'h1E0,  1'b1, 1'b0, 14'h1FE0, 1'b1}};
    vt[4]  = '{22'd500,                8'd0,   '{14'h1FFF, 9'd0,    1'b0, 1'b1, 14'h1FFF, 1'b0}};
    vt[5]  = '{-22'sd5,                8'd0,   '{14'h2000, 9'd0,    1'b0, 1'b1, 14'h2000, 1'b0}};
    vt[6]  = '{-22'sd7,                8'd7,   '{14'h3FFF, 9'd0,    1'b0, 1'b0, 14'h3FFF, 1'b0}};
    vt[7]  = '{22'd6,                  8'd7,   '{14'd0,    9'd6,    1'b0, 1'b0, 14'd0,    1'b0}};
    vt[8]  = '{-22'sd6,                8'd7,   '{14'd0,    9'h1FA,  1'b0, 1'b0, 14'd0,    1'b0}};
    vt[9]  = '{22'd0,                  8'd3,   '{14'd0,    9'd0,    1'b0, 1'b0, 14'd0,    1'b0}};
    vt[10] = '{22'd8191,               8'd1,   '{14'h1FFF, 9'd0,    1'b0, 1'b0, 14'h1FFF, 1'b0}};
    vt[11] = '{22'd8192,               8'd1,   '{14'h1FFF, 9'd0,    1'b1, 1'b0, 14'h2000, 1'b1}};
    vt[12] = '{-22'sd8192,             8'd1,   '{14'h2000, 9'd0,    1'b0, 1'b0, 14'h2000, 1'b0}};
    vt[13] = '{-22'sd8193,             8'd1,   '{14'h2000, 9'd0,    1'b1, 1'b0, 14'h1FFF, 1'b1}};

    ap_rst_n = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0; out_ready = 1'b0;
    #1;
    chk_reset_vals("reset_low");
    repeat (3) @(posedge ap_clk);
    #2 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk_reset_vals("after_release");

    for (int i = 0; i < 14; i++) begin
      run_op(vt[i].a, vt[i].b, (i == 0) ? 5 : (i % 3), vt[i].e);
    end

    // Reset in the middle of CALC, then a clean operation afterwards.
    din0 = 22'd1000; din1 = 8'd7; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge ap_clk);
    #1 ap_rst_n = 1'b0;
    #1 chk_reset_vals("reset_mid_calc");
    @(posedge ap_clk); #2 ap_rst_n = 1'b1;
    run_op(22'd1000, 8'd7, 0, model(22'd1000, 8'd7));

    // Reset while a divide-by-zero result waits in DONE.
    din0 = 22'd500; din1 = 8'd0; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    chk("dz_done_valid", {31'd0, out_valid_s}, 32'd1);
    ap_rst_n = 1'b0;
    #1 chk_reset_vals("reset_mid_done");
    @(posedge ap_clk); #2 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk_reset_vals("no_stale");

    // Back-to-back requests with the consumer always ready.
    din0 = 22'd1000; din1 = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (in_ready_s) acc.push_back(c);
      if (out_valid_s) chk("b2b_quot", {18'd0, quot_s}, 32'd142);
      @(posedge ap_clk); #1;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", acc.size(), 32'd3);
    if (acc.size() >= 3) begin
      chk("b2b_gap1", acc[1] - acc[0], 32'd24);
      chk("b2b_gap2", acc[2] - acc[1], 32'd24);
    end
    for (int c = 0; c < 40 && !in_ready_s; c++) begin
      @(posedge ap_clk); #1;
    end
    out_ready = 1'b0;
    chk("b2b_idle", {31'd0, in_ready_s}, 32'd1);

    for (int i = 0; i < 60; i++) begin
      logic [21:0] a;
      logic [7:0]  b;
      a = 22'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 8'd0;
        1, 2:    b = 8'($urandom_range(1, 4));
        default: b = 8'($urandom_range(1, 255));
      endcase
      if ($urandom_range(0, 3) == 0) a = 22'($signed(14'($urandom)));
      run_op(a, b, $urandom_range(0, 3), model(a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
